pkt_dispatch_sched: RTL and testbench

// Scheduler for the read side (port B) of the 192-bit packet memory filled by the UART loader.
// - Starts on the loader's done pulse.
// - Reads packets 0..NUM_PKTS-1 one at a time and pushes each to one of NUM_LANES worker lanes, round-robin.
// - Pulses done_transmitting so the loader re-arms for the next batch.

---
 rtl/pkt_mem_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/var_count.sv | 22 ++
 rtl/pkt_dispatch_sched.sv | 168 ++++++++++++++++
 tb/tb_pkt_dispatch_sched.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_mem_pkg.sv
// Shared definitions for the 192-bit packet memory: loader and dispatch scheduler.
package pkt_mem_pkg;

  localparam int unsigned PKT_W      = 192;
  localparam int unsigned MEM_ADDR_W = 11;
  localparam int unsigned BATCH_PKTS = 1000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    FINISH
  } sched_state_t;

  // Increment with wrap at n (n >= 1).
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int unsigned cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand     = (32'(ptr) + k) % N;
      cand_idx = IDX_W'(cand);
      if (!grant_vld && req[cand_idx]) begin
        grant_vld           = 1'b1;
        grant_oh[cand_idx]  = 1'b1;
        grant_idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/var_count.sv
// Common up-counter with synchronous clear and increment enable.
module var_count #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pkt_dispatch_sched.sv
// Port-B read scheduler: fetches each packet of a batch and hands it to a worker lane round-robin.
// Optional stall statistics enabled by defining PKT_DISPATCH_STALL_STATS_EN.
module pkt_dispatch_sched
  import pkt_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = PKT_W,
  parameter int unsigned ADDR_W    = MEM_ADDR_W,
  parameter int unsigned NUM_PKTS  = BATCH_PKTS,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_done,
  input  logic                 abort,
  output logic                 enB,
  output logic [ADDR_W-1:0]    addrB,
  input  logic [DATA_W-1:0]    dataFromB,
  input  logic [NUM_LANES-1:0] lane_req,
  output logic [NUM_LANES-1:0] lane_push,
  output logic [DATA_W-1:0]    lane_data,
  output logic                 busy,
  output logic                 done_transmitting,
  output logic [ADDR_W:0]      pkt_count,
  output logic [15:0]          stall_cycles
);

  localparam int unsigned LANE_W = $clog2(NUM_LANES);
  localparam int unsigned LAT_W  = 3;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PKTS - 1);

  sched_state_t state, state_nx;

  logic [ADDR_W-1:0]    addr;
  logic [ADDR_W-1:0]    fetch_addr;
  logic [LAT_W-1:0]     wait_cnt;
  logic [DATA_W-1:0]    hold_q;
  logic [LANE_W-1:0]    rr_ptr;
  logic [NUM_LANES-1:0] grant_oh;
  logic [LANE_W-1:0]    grant_idx;
  logic                 grant_vld;
  logic                 last_pkt;
  logic                 start;
  logic                 capture;
  logic                 push;

  assign last_pkt   = (addr == LAST_ADDR);
  assign fetch_addr = start ? '0 : addr + ADDR_W'(1);

  rr_arbiter #(.N(NUM_LANES)) u_arb (
    .req       (lane_req),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-cycle strobes; abort overrides everything outside IDLE.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    capture  = 1'b0;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (load_done && !abort) begin
          state_nx = FETCH;
          start    = 1'b1;
        end
      end
      FETCH: state_nx = WAIT;
      WAIT: begin
        if (wait_cnt == '0) begin
          state_nx = HOLD;
          capture  = 1'b1;
        end
      end
      HOLD: begin
        if (grant_vld) begin
          push     = 1'b1;
          state_nx = last_pkt ? FINISH : FETCH;
        end
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      start    = 1'b0;
      capture  = 1'b0;
      push     = 1'b0;
    end
  end

  assign lane_push = push ? grant_oh : '0;
  assign lane_data = hold_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enB               <= 1'b0;
      addrB             <= '0;
      busy              <= 1'b0;
      done_transmitting <= 1'b0;
      wait_cnt          <= '0;
      hold_q            <= '0;
      rr_ptr            <= '0;
    end else begin
      enB               <= (state_nx == FETCH);
      busy              <= (state_nx inside {FETCH, WAIT, HOLD});
      done_transmitting <= (state_nx == FINISH);
      if (state_nx == FETCH) begin
        addrB <= fetch_addr;
      end
      if (state == FETCH) begin
        wait_cnt <= LAT_W'(RD_LAT - 1);
      end else if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - LAT_W'(1);
      end
      if (capture) begin
        hold_q <= dataFromB;
      end
      if (push) begin
        rr_ptr <= LANE_W'(wrap_inc(32'(grant_idx), NUM_LANES));
      end
    end
  end

  var_count #(.W(ADDR_W)) u_addr_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (start),
    .inc   (push && !last_pkt),
    .count (addr)
  );

  var_count #(.W(CNT_W)) u_pkt_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (start),
    .inc   (push),
    .count (pkt_count)
  );

`ifdef PKT_DISPATCH_STALL_STATS_EN
  // Cycles a packet sat in HOLD with no lane asking for it; saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (start) begin
      stall_cycles <= '0;
    end else if (state == HOLD && lane_req == '0 && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pkt_dispatch_sched.sv
// Randomized bench for pkt_dispatch_sched against a transaction-timed reference model.
module tb_pkt_dispatch_sched;
  import pkt_mem_pkg::*;

  localparam int unsigned DATA_W    = 192;
  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned NUM_PKTS  = 1000;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned RD_LAT    = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 load_done, abort;
  logic                 enB;
  logic [ADDR_W-1:0]    addrB;
  logic [DATA_W-1:0]    dataFromB;
  logic [NUM_LANES-1:0] lane_req, lane_push;
  logic [DATA_W-1:0]    lane_data;
  logic                 busy, done_transmitting;
  logic [ADDR_W:0]      pkt_count;
  logic [15:0]          stall_cycles;

  pkt_dispatch_sched #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PKTS(NUM_PKTS),
    .NUM_LANES(NUM_LANES), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clock), .reset(reset), .load_done(load_done), .abort(abort),
    .enB(enB), .addrB(addrB), .dataFromB(dataFromB),
    .lane_req(lane_req), .lane_push(lane_push), .lane_data(lane_data),
    .busy(busy), .done_transmitting(done_transmitting),
    .pkt_count(pkt_count), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  // Packet memory with an RD_LAT-deep read pipe; idle slots carry junk.
  logic [DATA_W-1:0] mem [NUM_PKTS];
  logic [DATA_W-1:0] pipe [RD_LAT];

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  always @(posedge clock) begin
    if (enB && int'(addrB) < NUM_PKTS) pipe[0] <= mem[addrB];
    else                               pipe[0] <= rand_word();
    for (int s = 1; s < RD_LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign dataFromB = pipe[RD_LAT-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: batch progress expressed as packet index and the cycle its data is presentable.
  int   cyc;
  bit   m_act, m_fin;
  int   m_idx, m_cnt, m_rr, m_ready, m_stall;
  int   m_last_addr;
  int   push_cyc_log[$];
  int   push_lane_log[$];
  int   reads[NUM_PKTS];
  int   batch_pushes;
  bit   done_seen;

  function automatic int first_req(input logic [NUM_LANES-1:0] req, input int rr);
    for (int k = 0; k < NUM_LANES; k++) begin
      if (req[(rr + k) % NUM_LANES]) return (rr + k) % NUM_LANES;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_act = 0; m_fin = 0; m_idx = 0; m_cnt = 0; m_rr = 0;
    m_ready = 0; m_stall = 0; m_last_addr = 0;
  endtask

  task automatic step(input logic ld, input logic ab, input logic [NUM_LANES-1:0] req);
    bit hold_ph, exp_en, fin_nx;
    int g;
    logic [NUM_LANES-1:0] exp_push;
    int exp_addr, exp_stall;
    hold_ph  = m_act && cyc >= m_ready;
    exp_push = '0;
    g        = -1;
    if (hold_ph && !ab && req != '0) begin
      g        = first_req(req, m_rr);
      exp_push = NUM_LANES'(1) << g;
    end
    exp_en   = m_act && (cyc == m_ready - int'(RD_LAT) - 1);
    exp_addr = exp_en ? m_idx : m_last_addr;
`ifdef PKT_DISPATCH_STALL_STATS_EN
    exp_stall = m_stall;
`else
    exp_stall = 0;
`endif
    check_eq("lane_push", DATA_W'(lane_push), DATA_W'(exp_push));
    if (hold_ph) check_eq("lane_data", lane_data, mem[m_idx]);
    check_eq("enB", DATA_W'(enB), DATA_W'(exp_en));
    check_eq("addrB", DATA_W'(addrB), DATA_W'(exp_addr));
    check_eq("busy", DATA_W'(busy), DATA_W'(m_act));
    check_eq("done", DATA_W'(done_transmitting), DATA_W'(m_fin));
    check_eq("pkt_count", DATA_W'(pkt_count), DATA_W'(m_cnt));
    check_eq("stall_cycles", DATA_W'(stall_cycles), DATA_W'(exp_stall));
    if (lane_push != '0) begin
      push_cyc_log.push_back(cyc);
      push_lane_log.push_back($clog2(int'(lane_push)));
      batch_pushes++;
    end
    if (enB && int'(addrB) < NUM_PKTS) reads[addrB]++;
    if (done_transmitting) done_seen = 1;
    if (exp_en) m_last_addr = m_idx;
    // Advance the model to the next cycle.
    fin_nx = 0;
    if (hold_ph && req == '0 && m_stall < 16'hFFFF) m_stall++;
    if (m_act) begin
      if (ab) begin
        m_act = 0;
      end else if (g >= 0) begin
        m_cnt++;
        m_rr = (g + 1) % NUM_LANES;
        if (m_idx == NUM_PKTS - 1) begin
          m_act  = 0;
          fin_nx = 1;
        end else begin
          m_idx++;
          m_ready = cyc + RD_LAT + 2;
        end
      end
    end else if (!m_fin && ld && !ab) begin
      m_act = 1; m_idx = 0; m_cnt = 0; m_stall = 0;
      m_ready = cyc + RD_LAT + 2;
    end
    m_fin = fin_nx;
  endtask

  task automatic tick(input logic ld, input logic ab, input logic [NUM_LANES-1:0] req);
    @(posedge clock);
    #1;
    load_done = ld; abort = ab; lane_req = req;
    @(negedge clock);
    step(ld, ab, req);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; load_done = 1'b0; abort = 1'b0; lane_req = '0;
    #1;
    check_eq("rst_enB", DATA_W'(enB), '0);
    check_eq("rst_addrB", DATA_W'(addrB), '0);
    check_eq("rst_lane_push", DATA_W'(lane_push), '0);
    check_eq("rst_lane_data", lane_data, '0);
    check_eq("rst_busy", DATA_W'(busy), '0);
    check_eq("rst_done", DATA_W'(done_transmitting), '0);
    check_eq("rst_pkt_count", DATA_W'(pkt_count), '0);
    check_eq("rst_stall", DATA_W'(stall_cycles), '0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    step(1'b0, 1'b0, '0);
    cyc++;
  endtask

  initial begin
    int b0, guard, ones;
    cyc = 0; batch_pushes = 0; done_seen = 0;
    load_done = 1'b0; abort = 1'b0; lane_req = '0; reset = 1'b1;
    for (int i = 0; i < NUM_PKTS; i++) mem[i] = rand_word();
    for (int s = 0; s < RD_LAT; s++) pipe[s] = '0;
    model_reset();
    do_reset();

    // Basic batch timing with all lanes requesting.
    b0 = cyc;
    tick(1'b1, 1'b0, 4'hF);
    repeat (16) tick(1'b0, 1'b0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      check_eq("basic_push_cycle", DATA_W'(push_cyc_log[k] - b0), DATA_W'(4 * (k + 1)));
      check_eq("basic_push_lane", DATA_W'(push_lane_log[k]), DATA_W'(k));
    end

    // Only lanes 1 and 3 request.
    repeat (24) tick(1'b0, 1'b0, 4'b1010);
    for (int k = 0; k < 6; k++)
      check_eq("skip_lane", DATA_W'(push_lane_log[4 + k]), DATA_W'((k % 2 == 0) ? 1 : 3));

    // Stall ten cycles in HOLD.
    guard = 0;
    while (!(cyc >= m_ready) && guard < 20) begin
      tick(1'b0, 1'b0, '0);
      guard++;
    end
    repeat (10) tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 4'hF);
`ifdef PKT_DISPATCH_STALL_STATS_EN
    check_eq("stall_total", DATA_W'(stall_cycles), DATA_W'(10));
`else
    check_eq("stall_total", DATA_W'(stall_cycles), DATA_W'(0));
`endif
    tick(1'b0, 1'b1, 4'hF);
    tick(1'b0, 1'b0, 4'hF);

    // Abort in WAIT of packet 2.
    tick(1'b1, 1'b0, 4'hF);
    guard = 0;
    while (!(m_idx == 2 && cyc == m_ready - int'(RD_LAT)) && guard < 100) begin
      tick(1'b0, 1'b0, 4'hF);
      guard++;
    end
    tick(1'b0, 1'b1, 4'hF);
    tick(1'b0, 1'b0, 4'hF);
    check_eq("abort_pkt_count", DATA_W'(pkt_count), DATA_W'(2));
    check_eq("abort_busy", DATA_W'(busy), '0);

    // abort beats load_done in IDLE.
    tick(1'b1, 1'b1, 4'hF);
    tick(1'b0, 1'b0, 4'hF);
    check_eq("abort_ld_busy", DATA_W'(busy), '0);

    // Restart, ignore load_done while busy, then reset in HOLD.
    tick(1'b1, 1'b0, 4'hF);
    tick(1'b0, 1'b0, '0);
    check_eq("restart_enB", DATA_W'(enB), DATA_W'(1));
    check_eq("restart_addrB", DATA_W'(addrB), '0);
    guard = 0;
    while (!(cyc >= m_ready) && guard < 20) begin
      tick(1'b1, 1'b0, '0);
      guard++;
    end
    tick(1'b0, 1'b0, '0);
    do_reset();

    // Full batch with random lane requests.
    for (int i = 0; i < NUM_PKTS; i++) reads[i] = 0;
    batch_pushes = 0; done_seen = 0;
    tick(1'b1, 1'b0, NUM_LANES'($urandom));
    guard = 0;
    while (!done_seen && guard < 20000) begin
      tick(($urandom % 50) == 0, 1'b0, NUM_LANES'($urandom));
      guard++;
    end
    check_eq("full_timeout", DATA_W'(done_seen), DATA_W'(1));
    tick(1'b0, 1'b0, 4'hF);
    check_eq("full_pushes", DATA_W'(batch_pushes), DATA_W'(NUM_PKTS));
    check_eq("full_pkt_count", DATA_W'(pkt_count), DATA_W'(NUM_PKTS));
    ones = 0;
    for (int i = 0; i < NUM_PKTS; i++) if (reads[i] == 1) ones++;
    check_eq("full_reads_once", DATA_W'(ones), DATA_W'(NUM_PKTS));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
